// File: rtl/fft_pkg.sv
// Shared types and helpers for the in-place radix-2 DIT FFT address sequencer.
package fft_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } fft_state_t;

  // Cycles from the start-accept edge to the done pulse.
  function automatic int calc_done_lat(input int log2n, input int bf_lat);
    return log2n * ((1 << log2n) / 2 + bf_lat) + 1;
  endfunction

endpackage

// File: rtl/fft_delay_line.sv
// Fixed-depth shift register aligning write-back strobes and addresses with the
// butterfly output; a synchronous flush empties every stage in one cycle.
module fft_delay_line #(
  parameter int DEPTH = 3,
  parameter int WIDTH = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [DEPTH-1:0][WIDTH-1:0] pipe_q, pipe_d;

  always_comb begin
    // NOTE: assign a default to every always_comb output first so no path leaves it unassigned and infers a latch.
    pipe_d = pipe_q;
    if (flush) begin
      pipe_d = '0;
    end else begin
      pipe_d[0] = din;
      for (int i = 1; i < DEPTH; i++) begin
        pipe_d[i] = pipe_q[i-1];
      end
    end
  end

  // NOTE: this is a shallow register pipe, not a RAM, so every stage takes the reset; a deep memory array would not.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: non-blocking assignments in sequential blocks so every flop samples pre-edge values.
    if (rst) pipe_q <= '0;
    else     pipe_q <= pipe_d;
  end

  assign dout = pipe_q[DEPTH-1];

endmodule

// File: rtl/fft_addr_ctrl.sv
// Address, twiddle and write-back sequencer for an in-place radix-2 DIT FFT.
// Define FFT_INVERSE_EN to add the inv input and tw_conj output (inverse transform).
module fft_addr_ctrl
  import fft_pkg::*;
#(
  parameter int LOG2N  = 3,
  parameter int BF_LAT = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
`ifdef FFT_INVERSE_EN
  input  logic             inv,
  output logic             tw_conj,
`endif
  output logic             busy,
  output logic             done,
  output logic [LOG2N-1:0] stage,
  output logic             rd_en,
  output logic [LOG2N-1:0] rd_addr_a,
  output logic [LOG2N-1:0] rd_addr_b,
  output logic [LOG2N-2:0] tw_idx,
  output logic             wr_en,
  output logic [LOG2N-1:0] wr_addr_a,
  output logic [LOG2N-1:0] wr_addr_b
);

  localparam int HALF_N = 1 << (LOG2N - 1);
  localparam int DW     = (BF_LAT > 1) ? $clog2(BF_LAT) : 1;
  localparam int DL_W   = 1 + 2 * LOG2N;

  fft_state_t       state_q, state_d;
  logic [LOG2N-1:0] stage_q, stage_d;
  logic [LOG2N-1:0] j_q, j_d;
  logic [LOG2N-1:0] bf_cnt_q, bf_cnt_d;
  logic [DW-1:0]    drain_cnt_q, drain_cnt_d;
  logic             rd_en_q, rd_en_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [LOG2N-1:0] rd_addr_a_q, rd_addr_a_d;
  logic [LOG2N-1:0] rd_addr_b_q, rd_addr_b_d;
  logic [LOG2N-2:0] tw_idx_q, tw_idx_d;
  logic             accept, flush;

  // Successor of the current butterfly within the stage: step k by 2h, and
  // when k runs past N move to the next twiddle group j.
  logic [LOG2N:0]   h_w, sum_w;
  logic             wrap;
  logic [LOG2N-1:0] j_nxt, a_nxt, tw_shift;

  assign h_w      = (LOG2N+1)'(1) << stage_q;
  assign sum_w    = {1'b0, rd_addr_a_q} + (h_w << 1);
  assign wrap     = sum_w[LOG2N];
  assign j_nxt    = wrap ? j_q + LOG2N'(1) : j_q;
  assign a_nxt    = wrap ? j_nxt : sum_w[LOG2N-1:0];
  assign tw_shift = LOG2N'(LOG2N - 1) - stage_q;

  assign accept = (state_q == IDLE) && start && !abort;
  assign flush  = abort && (state_q != IDLE);

  always_comb begin
    state_d     = state_q;
    stage_d     = stage_q;
    j_d         = j_q;
    bf_cnt_d    = bf_cnt_q;
    drain_cnt_d = drain_cnt_q;
    rd_en_d     = 1'b0;
    rd_addr_a_d = rd_addr_a_q;
    rd_addr_b_d = rd_addr_b_q;
    tw_idx_d    = tw_idx_q;
    busy_d      = busy_q;
    done_d      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d     = ISSUE;
          stage_d     = '0;
          j_d         = '0;
          bf_cnt_d    = '0;
          rd_en_d     = 1'b1;
          rd_addr_a_d = '0;
          rd_addr_b_d = LOG2N'(1);
          tw_idx_d    = '0;
          busy_d      = 1'b1;
        end
      end

      ISSUE: begin
        if (bf_cnt_q == LOG2N'(HALF_N - 1)) begin
          state_d     = DRAIN;
          drain_cnt_d = '0;
        end else begin
          bf_cnt_d    = bf_cnt_q + LOG2N'(1);
          j_d         = j_nxt;
          rd_en_d     = 1'b1;
          rd_addr_a_d = a_nxt;
          rd_addr_b_d = a_nxt + h_w[LOG2N-1:0];
          tw_idx_d    = (LOG2N-1)'(j_nxt << tw_shift);
        end
      end

      DRAIN: begin
        if (drain_cnt_q == DW'(BF_LAT - 1)) begin
          if (stage_q == LOG2N'(LOG2N - 1)) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d     = ISSUE;
            stage_d     = stage_q + LOG2N'(1);
            j_d         = '0;
            bf_cnt_d    = '0;
            rd_en_d     = 1'b1;
            rd_addr_a_d = '0;
            rd_addr_b_d = LOG2N'(h_w << 1);
            tw_idx_d    = '0;
          end
        end else begin
          drain_cnt_d = drain_cnt_q + DW'(1);
        end
      end

      DONE: begin
        state_d     = IDLE;
        busy_d      = 1'b0;
        stage_d     = '0;
        rd_addr_a_d = '0;
        rd_addr_b_d = '0;
        tw_idx_d    = '0;
      end

      default: state_d = IDLE;
    endcase

    // Cancel wins over everything, including a simultaneous done.
    if (flush) begin
      state_d     = IDLE;
      rd_en_d     = 1'b0;
      busy_d      = 1'b0;
      done_d      = 1'b0;
      stage_d     = '0;
      rd_addr_a_d = '0;
      rd_addr_b_d = '0;
      tw_idx_d    = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      stage_q     <= '0;
      j_q         <= '0;
      bf_cnt_q    <= '0;
      drain_cnt_q <= '0;
      rd_en_q     <= 1'b0;
      rd_addr_a_q <= '0;
      rd_addr_b_q <= '0;
      tw_idx_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      stage_q     <= stage_d;
      j_q         <= j_d;
      bf_cnt_q    <= bf_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      rd_en_q     <= rd_en_d;
      rd_addr_a_q <= rd_addr_a_d;
      rd_addr_b_q <= rd_addr_b_d;
      tw_idx_q    <= tw_idx_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  logic [DL_W-1:0] wb_data;

  fft_delay_line #(
    .DEPTH (BF_LAT),
    .WIDTH (DL_W)
  ) u_delay (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .din   ({rd_en_q, rd_addr_a_q, rd_addr_b_q}),
    .dout  (wb_data)
  );

  assign wr_en     = wb_data[DL_W-1];
  assign wr_addr_a = wb_data[2*LOG2N-1:LOG2N];
  assign wr_addr_b = wb_data[LOG2N-1:0];

`ifdef FFT_INVERSE_EN
  // Direction is captured at accept so a mid-run toggle of inv has no effect.
  logic inv_q, inv_d, tw_conj_q, tw_conj_d;

  always_comb begin
    inv_d     = accept ? inv : inv_q;
    tw_conj_d = rd_en_d & inv_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inv_q     <= 1'b0;
      tw_conj_q <= 1'b0;
    end else begin
      inv_q     <= inv_d;
      tw_conj_q <= tw_conj_d;
    end
  end

  assign tw_conj = tw_conj_q;
`endif

  assign busy      = busy_q;
  assign done      = done_q;
  assign stage     = stage_q;
  assign rd_en     = rd_en_q;
  assign rd_addr_a = rd_addr_a_q;
  assign rd_addr_b = rd_addr_b_q;
  assign tw_idx    = tw_idx_q;

endmodule

// File: tb/tb_fft_addr_ctrl.sv
// Bench for fft_addr_ctrl: a cycle-offset model of the FFT schedule checks two
// instances (LOG2N=3/BF_LAT=3 and LOG2N=4/BF_LAT=1) every cycle, plus literal pins.
module tb_fft_addr_ctrl;

  logic clk = 1'b0;
  logic rst;
  logic start, abort, start2, abort2;

  logic       d1_busy, d1_done, d1_rd_en, d1_wr_en;
  logic [2:0] d1_stage, d1_ra, d1_rb, d1_wa, d1_wb;
  logic [1:0] d1_tw;

  logic       d2_busy, d2_done, d2_rd_en, d2_wr_en;
  logic [3:0] d2_stage, d2_ra, d2_rb, d2_wa, d2_wb;
  logic [2:0] d2_tw;

`ifdef FFT_INVERSE_EN
  logic inv, d1_tw_conj, d2_tw_conj;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  fft_addr_ctrl #(.LOG2N(3), .BF_LAT(3)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
`ifdef FFT_INVERSE_EN
    .inv(inv), .tw_conj(d1_tw_conj),
`endif
    .busy(d1_busy), .done(d1_done), .stage(d1_stage), .rd_en(d1_rd_en),
    .rd_addr_a(d1_ra), .rd_addr_b(d1_rb), .tw_idx(d1_tw),
    .wr_en(d1_wr_en), .wr_addr_a(d1_wa), .wr_addr_b(d1_wb)
  );

  fft_addr_ctrl #(.LOG2N(4), .BF_LAT(1)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .abort(abort2),
`ifdef FFT_INVERSE_EN
    .inv(1'b0), .tw_conj(d2_tw_conj),
`endif
    .busy(d2_busy), .done(d2_done), .stage(d2_stage), .rd_en(d2_rd_en),
    .rd_addr_a(d2_ra), .rd_addr_b(d2_rb), .tw_idx(d2_tw),
    .wr_en(d2_wr_en), .wr_addr_a(d2_wa), .wr_addr_b(d2_wb)
  );

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // idx-th butterfly of the whole transform, straight from the loop nest.
  function automatic void get_pair(input int log2n, input int idx,
                                   output int s_o, output int a_o, output int b_o, output int tw_o);
    int n, cnt, h;
    n = 1 << log2n;
    cnt = 0;
    s_o = 0; a_o = 0; b_o = 0; tw_o = 0;
    for (int s = 0; s < log2n; s++) begin
      h = 1 << s;
      for (int j = 0; j < h; j++) begin
        for (int k = j; k < n; k += 2 * h) begin
          if (cnt == idx) begin
            s_o = s; a_o = k; b_o = k + h; tw_o = j << (log2n - 1 - s);
          end
          cnt++;
        end
      end
    end
  endfunction

  function automatic int run_len(input int log2n, input int bflat);
    return log2n * ((1 << log2n) / 2 + bflat) + 1;
  endfunction

  // Whether offset t (cycles after accept) carries a read.
  function automatic bit is_read(input int log2n, input int bflat, input int t);
    int p;
    p = (1 << log2n) / 2 + bflat;
    return (t >= 1) && (t <= log2n * p) && (((t - 1) % p) < (1 << log2n) / 2);
  endfunction

  function automatic int read_idx(input int log2n, input int bflat, input int t);
    int n2, p;
    n2 = (1 << log2n) / 2;
    p = n2 + bflat;
    return ((t - 1) / p) * n2 + (t - 1) % p;
  endfunction

  function automatic int next_t(input int t, input bit s, input bit a, input int lat);
    if (t == 0) return (s && !a) ? 1 : 0;
    if (a || t == lat) return 0;
    return t + 1;
  endfunction

  task automatic cmp(input string tg, input int log2n, input int bflat, input int t,
                     input int busy, input int done, input int rd, input int st,
                     input int ra, input int rb, input int tw,
                     input int wr, input int wa, input int wb);
    int lat, s, a, b, w;
    bit e_rd, e_wr;
    lat  = run_len(log2n, bflat);
    e_rd = is_read(log2n, bflat, t);
    e_wr = is_read(log2n, bflat, t - bflat);
    check({tg, " busy"}, busy, int'(t >= 1 && t <= lat));
    check({tg, " done"}, done, int'(t == lat));
    check({tg, " rd_en"}, rd, int'(e_rd));
    check({tg, " wr_en"}, wr, int'(e_wr));
    if (e_rd) begin
      get_pair(log2n, read_idx(log2n, bflat, t), s, a, b, w);
      check({tg, " stage"}, st, s);
      check({tg, " rd_addr_a"}, ra, a);
      check({tg, " rd_addr_b"}, rb, b);
      check({tg, " tw_idx"}, tw, w);
    end
    if (e_wr) begin
      get_pair(log2n, read_idx(log2n, bflat, t - bflat), s, a, b, w);
      check({tg, " wr_addr_a"}, wa, a);
      check({tg, " wr_addr_b"}, wb, b);
    end
  endtask

  // Model state: offset since accept (0 = idle) per instance.
  int m1_t = 0;
  int m2_t = 0;
  bit m1_inv = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m1_t   <= 0;
      m2_t   <= 0;
      m1_inv <= 1'b0;
    end else begin
      m1_t <= next_t(m1_t, start, abort, run_len(3, 3));
      m2_t <= next_t(m2_t, start2, abort2, run_len(4, 1));
`ifdef FFT_INVERSE_EN
      if (m1_t == 0 && start && !abort) m1_inv <= inv;
`endif
    end
  end

  always @(negedge clk) begin
    cmp("d1", 3, 3, m1_t, d1_busy, d1_done, d1_rd_en, d1_stage, d1_ra, d1_rb, d1_tw,
        d1_wr_en, d1_wa, d1_wb);
    cmp("d2", 4, 1, m2_t, d2_busy, d2_done, d2_rd_en, d2_stage, d2_ra, d2_rb, d2_tw,
        d2_wr_en, d2_wa, d2_wb);
`ifdef FFT_INVERSE_EN
    check("d1 tw_conj", d1_tw_conj, int'(is_read(3, 3, m1_t) && m1_inv));
    check("d2 tw_conj", d2_tw_conj, 0);
`endif
  end

  task automatic pin_rd(input string name, input int a, input int b, input int tw);
    check({name, " rd_en"}, d1_rd_en, 1);
    check({name, " a"}, d1_ra, a);
    check({name, " b"}, d1_rb, b);
    check({name, " tw"}, d1_tw, tw);
  endtask

  task automatic pin_all_zero(input string name);
    check({name, " busy"}, d1_busy, 0);
    check({name, " done"}, d1_done, 0);
    check({name, " rd_en"}, d1_rd_en, 0);
    check({name, " wr_en"}, d1_wr_en, 0);
    check({name, " stage"}, d1_stage, 0);
    check({name, " rd_addr_a"}, d1_ra, 0);
    check({name, " rd_addr_b"}, d1_rb, 0);
    check({name, " tw_idx"}, d1_tw, 0);
    check({name, " wr_addr_a"}, d1_wa, 0);
    check({name, " wr_addr_b"}, d1_wb, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; start2 = 1'b0; abort2 = 1'b0;
`ifdef FFT_INVERSE_EN
    inv = 1'b0;
`endif
    // Reset values, then a quiet idle period.
    repeat (3) @(negedge clk);
    pin_all_zero("reset");
    check("reset d2 busy", d2_busy, 0);
    rst = 1'b0;
    repeat (10) begin
      @(negedge clk);
      check("idle busy", d1_busy, 0);
    end

    // Full run with an ignored start at 6 and a held start from 20.
    for (int c = 0; c <= 47; c++) begin
      if (c > 0) @(negedge clk);
      case (c)
        1:  pin_rd("run c1", 0, 1, 0);
        4:  begin
              pin_rd("run c4", 6, 7, 0);
              check("run c4 wr_en", d1_wr_en, 1);
              check("run c4 wr_a", d1_wa, 0);
              check("run c4 wr_b", d1_wb, 1);
            end
        7:  check("run c7 rd_en", d1_rd_en, 0);
        8:  pin_rd("run c8", 0, 2, 0);
        9:  begin pin_rd("run c9", 4, 6, 0); check("run c9 stage", d1_stage, 1); end
        10: pin_rd("run c10", 1, 3, 2);
        16: begin pin_rd("run c16", 1, 5, 1); check("run c16 stage", d1_stage, 2); end
        18: pin_rd("run c18", 3, 7, 3);
        21: begin
              check("run c21 wr_a", d1_wa, 3);
              check("run c21 wr_b", d1_wb, 7);
              check("run c21 done", d1_done, 0);
            end
        22: begin check("run c22 done", d1_done, 1); check("run c22 rd_en", d1_rd_en, 0); end
        23: begin check("run c23 busy", d1_busy, 0); check("run c23 done", d1_done, 0); end
        24: pin_rd("run c24", 0, 1, 0);
        45: check("run c45 done", d1_done, 1);
        default: ;
      endcase
      start = (c == 0) || (c == 6) || (c >= 20 && c <= 23);
    end
    start = 1'b0;

    // Abort mid-run, restart, then abort together with start in IDLE.
    for (int c = 0; c <= 42; c++) begin
      if (c > 0) @(negedge clk);
      case (c)
        10: begin
              check("abort c10 rd_en", d1_rd_en, 0);
              check("abort c10 wr_en", d1_wr_en, 0);
              check("abort c10 busy", d1_busy, 0);
            end
        11: check("abort c11 done", d1_done, 0);
        13: pin_rd("restart c13", 0, 1, 0);
        34: check("restart c34 done", d1_done, 1);
        41: check("abort+start c41 busy", d1_busy, 0);
        default: ;
      endcase
      start = (c == 0) || (c == 12) || (c == 40);
      abort = (c == 9) || (c == 40);
    end
    start = 1'b0; abort = 1'b0;

    // Asynchronous reset in the middle of a run.
    for (int c = 0; c <= 14; c++) begin
      if (c > 0) @(negedge clk);
      start = (c == 0);
      if (c == 9) begin
        check("pre-rst c9 rd_en", d1_rd_en, 1);
        #2 rst = 1'b1;
        #1 pin_all_zero("rst c9");
      end
      if (c == 10) rst = 1'b0;
      if (c == 12) check("post-rst c12 busy", d1_busy, 0);
    end

    // Second parameter set: LOG2N=4, BF_LAT=1.
    for (int c = 0; c <= 40; c++) begin
      if (c > 0) @(negedge clk);
      case (c)
        8:  begin
              check("d2 c8 a", d2_ra, 14);
              check("d2 c8 b", d2_rb, 15);
            end
        9:  check("d2 c9 rd_en", d2_rd_en, 0);
        10: begin
              check("d2 c10 a", d2_ra, 0);
              check("d2 c10 b", d2_rb, 2);
            end
        36: check("d2 c36 done", d2_done, 0);
        37: check("d2 c37 done", d2_done, 1);
        default: ;
      endcase
      start2 = (c == 0);
    end
    start2 = 1'b0;

`ifdef FFT_INVERSE_EN
    // Inverse run with inv toggling mid-run, then a forward run.
    for (int c = 0; c <= 24; c++) begin
      if (c > 0) @(negedge clk);
      if (c == 1) check("inv c1 tw_conj", d1_tw_conj, 1);
      if (c == 5) check("inv c5 tw_conj", d1_tw_conj, 0);
      if (c == 9) check("inv c9 tw_conj", d1_tw_conj, 1);
      start = (c == 0);
      inv   = (c == 0) ? 1'b1 : c[0];
    end
    for (int c = 0; c <= 24; c++) begin
      if (c > 0) @(negedge clk);
      if (c == 1) check("fwd c1 tw_conj", d1_tw_conj, 0);
      start = (c == 0);
      inv   = 1'b0;
    end
    start = 1'b0;
`endif

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
